// File: rtl/alu_operand_stage_pkg.sv
// rtl/alu_operand_stage_pkg.sv - ALU mode codes and operand-stage FSM state encodings
// Shared by the operand stage, the ALU and their benches.
package alu_operand_stage_pkg;

  localparam logic [2:0] MODE_ADD    = 3'd0;
  localparam logic [2:0] MODE_SUBST  = 3'd1;
  localparam logic [2:0] MODE_SHIFTR = 3'd2;
  localparam logic [2:0] MODE_SHIFTL = 3'd3;
  localparam logic [2:0] MODE_AND    = 3'd4;
  localparam logic [2:0] MODE_OR     = 3'd5;
  localparam logic [2:0] MODE_NOT    = 3'd6;
  localparam logic [2:0] MODE_XOR    = 3'd7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OPER = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_LOAD = 2'd3;

endpackage

// File: rtl/alu_operand_stage_reg_file.sv
// rtl/alu_operand_stage_reg_file.sv - reg_file_8x16: two read ports, debug read port, one write port
// r0 is hard zero: reads return 0 and writes to it are dropped.
module reg_file_8x16
  import alu_operand_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic [DATA_W-1:0] rdata2,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (waddr != '0)) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata1   = (raddr1   == '0) ? '0 : regs[raddr1];
  assign rdata2   = (raddr2   == '0) ? '0 : regs[raddr2];
  assign dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - operand fetch / writeback stage in front of the 16-bit ALU
// Optional ALU_FLAGS_EN adds registered zero/negative flags captured on ALU writeback.
module alu_operand_stage
  import alu_operand_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_load,
  input  logic [2:0]        in_op,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [ADDR_W-1:0] in_rs1,
  input  logic [ADDR_W-1:0] in_rs2,
  input  logic [DATA_W-1:0] in_imm,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [2:0]        alu_mode,
  input  logic [DATA_W-1:0] alu_result,
  output logic              done,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
`ifdef ALU_FLAGS_EN
  ,
  output logic              flag_z,
  output logic              flag_n
`endif
);

  logic [1:0]        state;
  logic [2:0]        lat_op;
  logic [ADDR_W-1:0] lat_rd;
  logic [ADDR_W-1:0] lat_rs1;
  logic [ADDR_W-1:0] lat_rs2;
  logic [DATA_W-1:0] lat_imm;

  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata;
  logic [DATA_W-1:0] rd_data1;
  logic [DATA_W-1:0] rd_data2;

  assign in_ready = (state == ST_IDLE);

  // Writeback happens on the last edge of either path; the LOAD path bypasses the ALU.
  assign rf_we    = (state == ST_EXEC) || (state == ST_LOAD);
  assign rf_wdata = (state == ST_LOAD) ? lat_imm : alu_result;

  reg_file_8x16 #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W)
  ) u_reg_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (rf_we),
    .waddr    (lat_rd),
    .wdata    (rf_wdata),
    .raddr1   (lat_rs1),
    .rdata1   (rd_data1),
    .raddr2   (lat_rs2),
    .rdata2   (rd_data2),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      done     <= 1'b0;
      alu_in1  <= '0;
      alu_in2  <= '0;
      alu_mode <= '0;
      lat_op   <= '0;
      lat_rd   <= '0;
      lat_rs1  <= '0;
      lat_rs2  <= '0;
      lat_imm  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            lat_op  <= in_op;
            lat_rd  <= in_rd;
            lat_rs1 <= in_rs1;
            lat_rs2 <= in_rs2;
            lat_imm <= in_imm;
            state   <= in_load ? ST_LOAD : ST_OPER;
          end
        end
        ST_OPER: begin
          alu_in1  <= rd_data1;
          alu_in2  <= rd_data2;
          alu_mode <= lat_op;
          state    <= ST_EXEC;
        end
        ST_EXEC: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        ST_LOAD: begin
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_n <= 1'b0;
    end else if (state == ST_EXEC) begin
      flag_z <= (alu_result == '0);
      flag_n <= alu_result[DATA_W-1];
    end
  end
`endif

endmodule
